// File: rtl/drum_step_sequencer.sv
// Pattern-driven one-shot trigger sequencer: walks a NUM_VOICES x NUM_STEPS hit pattern
// at a programmable step period. Optional swing on odd steps with `define SEQ_SWING_EN.
module drum_step_sequencer #(
    parameter int NUM_VOICES  = 4,
    parameter int NUM_STEPS   = 16,
    parameter int PERIOD_BITS = 24
) (
    input  logic                         mclk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [PERIOD_BITS-1:0]       step_period,
    input  logic                         pat_we,
    input  logic [$clog2(NUM_STEPS)-1:0] pat_addr,
    input  logic [NUM_VOICES-1:0]        pat_wdata,
`ifdef SEQ_SWING_EN
    input  logic [7:0]                   swing,
`endif
    output logic [NUM_VOICES-1:0]        trig,
    output logic                         step_strobe,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx
);
    localparam int IDX_W = $clog2(NUM_STEPS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_reg;
    logic [IDX_W-1:0]        step_reg;
    logic [PERIOD_BITS-1:0]  cnt_reg;
    logic [PERIOD_BITS-1:0]  period_reg;
    logic [NUM_VOICES-1:0]   pattern_reg [NUM_STEPS];
    logic [PERIOD_BITS-1:0]  period_next;

    // Periods below 2 would make back-to-back pulses, so they are clamped up to 2.
    assign period_next = (step_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : step_period;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STEPS; gi++) begin : g_pattern
            always_ff @(posedge mclk or negedge rst) begin
                if (!rst) begin
                    pattern_reg[gi] <= '0;
                end else if (pat_we && pat_addr == IDX_W'(gi)) begin
                    pattern_reg[gi] <= pat_wdata;
                end
            end
        end
    endgenerate

`ifdef SEQ_SWING_EN
    logic [PERIOD_BITS+7:0] swing_prod;
    logic [PERIOD_BITS-2:0] delay_next;
    logic                   pend_reg;
    logic [PERIOD_BITS-2:0] pend_cnt_reg;
    logic [IDX_W-1:0]       pend_idx_reg;

    assign swing_prod = (PERIOD_BITS+8)'(period_next) * (PERIOD_BITS+8)'(swing);
    assign delay_next = swing_prod[PERIOD_BITS+7:9];
`endif

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            step_reg     <= '0;
            cnt_reg      <= '0;
            period_reg   <= '0;
            trig         <= '0;
            step_strobe  <= 1'b0;
            step_idx     <= '0;
`ifdef SEQ_SWING_EN
            pend_reg     <= 1'b0;
            pend_cnt_reg <= '0;
            pend_idx_reg <= '0;
`endif
        end else begin
            trig        <= '0;
            step_strobe <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg  <= '0;
                    step_reg <= '0;
                    if (run) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    if (!run) begin
                        // Stop wins over a boundary or pending swung pulse on the same edge.
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        step_reg  <= '0;
`ifdef SEQ_SWING_EN
                        pend_reg  <= 1'b0;
`endif
                    end else begin
                        if (cnt_reg == '0) begin
                            period_reg <= period_next;
                            cnt_reg    <= PERIOD_BITS'(1);
                            step_reg   <= step_reg + 1'b1;
`ifdef SEQ_SWING_EN
                            if (step_reg[0] && delay_next != '0) begin
                                pend_reg     <= 1'b1;
                                pend_cnt_reg <= delay_next;
                                pend_idx_reg <= step_reg;
                            end else begin
                                trig        <= pattern_reg[step_reg];
                                step_strobe <= 1'b1;
                                step_idx    <= step_reg;
                            end
`else
                            trig        <= pattern_reg[step_reg];
                            step_strobe <= 1'b1;
                            step_idx    <= step_reg;
`endif
                        end else if (cnt_reg == period_reg - PERIOD_BITS'(1)) begin
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + PERIOD_BITS'(1);
                        end
`ifdef SEQ_SWING_EN
                        // D < P/2, so a delayed pulse never collides with a boundary fire.
                        if (pend_reg) begin
                            if (pend_cnt_reg == (PERIOD_BITS-1)'(1)) begin
                                pend_reg    <= 1'b0;
                                trig        <= pattern_reg[pend_idx_reg];
                                step_strobe <= 1'b1;
                                step_idx    <= pend_idx_reg;
                            end else begin
                                pend_cnt_reg <= pend_cnt_reg - (PERIOD_BITS-1)'(1);
                            end
                        end
`endif
                    end
                end
            endcase
        end
    end
endmodule
